// File: rtl/scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : scoreboard                                                  |
// | Brief  : In-order allocation/commit tracker for in-flight            |
// |          instructions with writeback capture, register clobber       |
// |          tracking and operand forwarding.                            |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+

package scoreboard_pkg;
  localparam int NR_SB_ENTRIES = 4;
  localparam int NR_WB_PORTS   = 2;
  localparam int TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);

  localparam logic [63:0] LD_ACCESS_FAULT = 64'd5;

  typedef enum logic [2:0] {
    NONE      = 3'd0,
    LSU       = 3'd1,
    ALU       = 3'd2,
    CTRL_FLOW = 3'd3,
    MULT      = 3'd4,
    CSR       = 3'd5
  } fu_t;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    fu_t                      fu;
    logic [7:0]               op;
    logic [4:0]               rs1;
    logic [4:0]               rs2;
    logic [4:0]               rd;
    logic [63:0]              result;
    logic                     valid;
    exception_t               ex;
  } scoreboard_entry_t;
endpackage

module scoreboard
  import scoreboard_pkg::TRANS_ID_BITS, scoreboard_pkg::fu_t, scoreboard_pkg::NONE,
         scoreboard_pkg::exception_t, scoreboard_pkg::scoreboard_entry_t;
#(
  parameter int NR_ENTRIES  = scoreboard_pkg::NR_SB_ENTRIES,
  parameter int NR_WB_PORTS = scoreboard_pkg::NR_WB_PORTS
) (
  input  logic                                         clk_i,
  input  logic                                         rst_ni,
  input  logic                                         flush_i,
  output logic                                         full_o,
  output fu_t               [31:0]                     rd_clobber_o,
  input  logic              [4:0]                      rs1_i,
  output logic              [63:0]                     rs1_o,
  output logic                                         rs1_valid_o,
  input  logic              [4:0]                      rs2_i,
  output logic              [63:0]                     rs2_o,
  output logic                                         rs2_valid_o,
  input  scoreboard_entry_t                            decoded_instr_i,
  input  logic                                         decoded_instr_valid_i,
  output logic                                         decoded_instr_ack_o,
  output scoreboard_entry_t                            issue_instr_o,
  output logic                                         issue_instr_valid_o,
  input  logic                                         issue_ack_i,
  output scoreboard_entry_t                            commit_instr_o,
  output logic                                         commit_valid_o,
  input  logic                                         commit_ack_i,
  input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]    trans_id_i,
  input  logic [NR_WB_PORTS-1:0][63:0]                 wdata_i,
  input  exception_t [NR_WB_PORTS-1:0]                 ex_i,
  input  logic [NR_WB_PORTS-1:0]                       wb_valid_i
);

  localparam logic [TRANS_ID_BITS:0] C_FULL_COUNT = (TRANS_ID_BITS+1)'(NR_ENTRIES);

  scoreboard_entry_t          r_mem   [NR_ENTRIES];
  scoreboard_entry_t          w_mem_d [NR_ENTRIES];
  logic [TRANS_ID_BITS-1:0]   r_issue_ptr, w_issue_ptr_d;
  logic [TRANS_ID_BITS-1:0]   r_commit_ptr, w_commit_ptr_d;
  logic [TRANS_ID_BITS:0]     r_count, w_count_d;
  logic [NR_ENTRIES-1:0]      w_alloc;
  logic [TRANS_ID_BITS-1:0]   w_scan_idx;
  logic                       w_issue;
  logic                       w_commit;

  // A slot is allocated when its distance from the commit pointer is below the count
  for (genvar k = 0; k < NR_ENTRIES; k++) begin : g_alloc
    assign w_alloc[k] = ({1'b0, TRANS_ID_BITS'(k) - r_commit_ptr}) < r_count;
  end

  assign full_o              = (r_count == C_FULL_COUNT);
  assign commit_valid_o      = (r_count != '0);
  assign commit_instr_o      = r_mem[r_commit_ptr];
  // A full buffer blocks issue even if a commit frees a slot this cycle
  assign issue_instr_valid_o = decoded_instr_valid_i & ~full_o & ~flush_i;
  assign decoded_instr_ack_o = issue_ack_i & issue_instr_valid_o;
  assign w_issue             = decoded_instr_ack_o;
  assign w_commit            = commit_ack_i & commit_valid_o;

  // Tag the decoded instruction with its slot and clear its completion flag
  always_comb begin
    issue_instr_o          = decoded_instr_i;
    issue_instr_o.trans_id = r_issue_ptr;
    issue_instr_o.valid    = 1'b0;
  end

  // Walk entries oldest to youngest so the youngest writer wins clobber and forwarding
  always_comb begin
    rs1_o       = '0;
    rs1_valid_o = 1'b0;
    rs2_o       = '0;
    rs2_valid_o = 1'b0;
    w_scan_idx  = r_commit_ptr;
    for (int r = 0; r < 32; r++) rd_clobber_o[r] = NONE;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      w_scan_idx = r_commit_ptr + TRANS_ID_BITS'(i);
      if (w_alloc[w_scan_idx]) begin
        rd_clobber_o[r_mem[w_scan_idx].rd] = r_mem[w_scan_idx].fu;
        if (r_mem[w_scan_idx].rd == rs1_i) begin
          rs1_o       = r_mem[w_scan_idx].result;
          rs1_valid_o = r_mem[w_scan_idx].valid;
        end
        if (r_mem[w_scan_idx].rd == rs2_i) begin
          rs2_o       = r_mem[w_scan_idx].result;
          rs2_valid_o = r_mem[w_scan_idx].valid;
        end
      end
    end
    rd_clobber_o[0] = NONE;
    if (rs1_i == '0) rs1_valid_o = 1'b0;
    if (rs2_i == '0) rs2_valid_o = 1'b0;
  end

  // Next state: writeback, then issue, then commit; flush overrides everything
  always_comb begin
    w_mem_d        = r_mem;
    w_issue_ptr_d  = r_issue_ptr;
    w_commit_ptr_d = r_commit_ptr;
    w_count_d      = r_count;
    // Ascending port order lets the highest port win on a shared trans_id
    for (int p = 0; p < NR_WB_PORTS; p++) begin
      if (wb_valid_i[p] && w_alloc[trans_id_i[p]]) begin
        w_mem_d[trans_id_i[p]].result = wdata_i[p];
        w_mem_d[trans_id_i[p]].valid  = 1'b1;
        if (ex_i[p].valid) w_mem_d[trans_id_i[p]].ex = ex_i[p];
      end
    end
    if (w_issue) begin
      w_mem_d[r_issue_ptr] = issue_instr_o;
      w_issue_ptr_d        = r_issue_ptr + 1'b1;
    end
    if (w_commit) begin
      w_mem_d[r_commit_ptr].valid = 1'b0;
      w_commit_ptr_d              = r_commit_ptr + 1'b1;
    end
    if (w_issue && !w_commit)      w_count_d = r_count + 1'b1;
    else if (!w_issue && w_commit) w_count_d = r_count - 1'b1;
    if (flush_i) begin
      w_issue_ptr_d  = '0;
      w_commit_ptr_d = '0;
      w_count_d      = '0;
      for (int k = 0; k < NR_ENTRIES; k++) w_mem_d[k].valid = 1'b0;
    end
  end

  // State register with asynchronous clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_issue_ptr  <= '0;
      r_commit_ptr <= '0;
      r_count      <= '0;
      for (int k = 0; k < NR_ENTRIES; k++) r_mem[k] <= '0;
    end else begin
      r_issue_ptr  <= w_issue_ptr_d;
      r_commit_ptr <= w_commit_ptr_d;
      r_count      <= w_count_d;
      for (int k = 0; k < NR_ENTRIES; k++) r_mem[k] <= w_mem_d[k];
    end
  end

endmodule
`default_nettype wire

// File: doc/scoreboard.md
# scoreboard

In-order allocation and commit tracker for up to NR_ENTRIES in-flight instructions (`scoreboard_entry`), sitting between decode and issue/commit. It hands decoded instructions to the issue stage and tags each with a transaction ID (`trans_id`). It collects results and exceptions from NR_WB_PORTS writeback ports and presents the oldest entry to commit. It also tracks which functional unit will write each architectural register, so issue can detect hazards and forward completed results.

## Interface
- NR_ENTRIES, default NR_SB_ENTRIES (4): entry count; must be a power of two.
- NR_WB_PORTS, default NR_WB_PORTS (2): number of writeback ports.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- flush_i  in  1  drop all in-flight entries.
- full_o  out  1  all NR_ENTRIES slots allocated.
- rd_clobber_o  out  32×fu_t  per-register FU of the youngest in-flight writer; NONE if there is none.
- rs1_i, rs2_i  in  5 each  operand register addresses from issue.
- rs1_o, rs2_o  out  64 each  forwarded operand values.
- rs1_valid_o, rs2_valid_o  out  1 each  the forwarded value is usable.
- decoded_instr_i  in  scoreboard_entry  instruction from decode.
- decoded_instr_valid_i  in  1  decode offers an instruction.
- decoded_instr_ack_o  out  1  decode may advance.
- issue_instr_o  out  scoreboard_entry  instruction to issue, with trans_id filled in.
- issue_instr_valid_o  out  1  issue_instr_o is valid.
- issue_ack_i  in  1  issue accepted the instruction.
- commit_instr_o  out  scoreboard_entry  oldest allocated entry.
- commit_valid_o  out  1  at least one entry is allocated.
- commit_ack_i  in  1  retire the oldest entry.
- trans_id_i  in  NR_WB_PORTS×TRANS_ID_BITS  writeback tags.
- wdata_i  in  NR_WB_PORTS×64  writeback results.
- ex_i  in  NR_WB_PORTS×exception  writeback exceptions.
- wb_valid_i  in  NR_WB_PORTS  writeback strobes.

## Operation
- State:
  - entry array mem[NR_ENTRIES];
  - issue_ptr and commit_ptr, TRANS_ID_BITS wide, wrap modulo NR_ENTRIES;
  - count, range 0..NR_ENTRIES (TRANS_ID_BITS+1 bits).
- full_o = (count == NR_ENTRIES).
- Issue path:
  - issue_instr_o = decoded_instr_i with trans_id = issue_ptr and valid = 0.
  - issue_instr_valid_o = decoded_instr_valid_i & ~full_o & ~flush_i.
  - decoded_instr_ack_o = issue_ack_i & issue_instr_valid_o.
  - On that ack: mem[issue_ptr] ← issue_instr_o, issue_ptr+1, count+1.
- Commit path:
  - commit_instr_o = mem[commit_ptr]; commit_valid_o = (count != 0).
  - On commit_ack_i with commit_valid_o: mem[commit_ptr].valid ← 0, commit_ptr+1, count−1.
  - commit_ack_i while count == 0 is ignored.
- Writeback, per port p with wb_valid_i[p]:
  - mem[trans_id_i[p]].result ← wdata_i[p] and .valid ← 1.
  - If ex_i[p].valid, .ex ← ex_i[p].
  - A writeback to an unallocated slot is ignored.
  - If two ports carry the same trans_id, the higher port index wins.
- Simultaneous issue and commit: both take effect and count is unchanged.
- When full_o = 1, issue is blocked even if a commit happens in the same cycle (no same-cycle slot reuse).
- rd_clobber_o[r]:
  - Scan allocated entries from oldest to youngest; the fu of the youngest entry with rd == r wins.
  - rd_clobber_o[0] = NONE always.
- Forwarding, rs1 (rs2 identical):
  - Select the youngest allocated entry with rd == rs1_i.
  - If that entry has valid == 1: rs1_o = result and rs1_valid_o = 1.
  - Otherwise rs1_valid_o = 0.
  - rs1_i == 0 → rs1_valid_o = 0.
  - Same-cycle writeback data is not forwarded.
- Flush:
  - Next state: all pointers and count = 0, all entry valid bits = 0.
  - Flush overrides issue, writeback and commit in the same cycle.
- Reset (async, rst_ni = 0):
  - all entries zero, pointers and count 0;
  - full_o = 0, commit_valid_o = 0, all rd_clobber_o = NONE, rs*_valid_o = 0.
  - Reset asserted mid-operation discards everything immediately.

## Timing
- Issue is combinational: decoded_instr_i → issue_instr_o, and issue_ack_i → decoded_instr_ack_o, in the same cycle.
- An entry acked in cycle N appears on commit_instr_o (if oldest) and in rd_clobber_o in cycle N+1.
- Writeback in cycle N → entry valid and result forwardable from cycle N+1.
- Commit ack in cycle N → next entry is presented in cycle N+1.
- full_o deasserts the cycle after the commit that frees a slot.
- There is no combinational path from commit_ack_i to any output.

## Test plan
- **Fill and drain:**
  - Issue 4 instructions (rd = 1..4, fu = ALU) on consecutive cycles → trans_id 0,1,2,3; full_o = 1 after the 4th.
  - A 5th issue shows issue_instr_valid_o = 0.
  - Commit all 4 → commit_valid_o = 0 and full_o = 0.
- **Writeback and commit order:**
  - Issue rd = 5 (id 0) and rd = 6 (id 1).
  - Port 1 writes id 1 = 0xBEEF, then port 0 writes id 0 = 0x1234.
  - commit_instr_o shows id 0 with result 0x1234 and valid = 1; after ack, id 1 with 0xBEEF.
- **Forwarding and clobber:**
  - Issue rd = 7 twice (fu LSU, then ALU) → rd_clobber_o[7] = ALU.
  - rs1_i = 7 → rs1_valid_o = 0 until the younger entry is written back with 0x55, then rs1_o = 0x55 and rs1_valid_o = 1.
- **Exception capture:** writeback with ex_i.valid = 1, cause = LD_ACCESS_FAULT, tval = 0x80 → commit_instr_o.ex carries cause 5, tval 0x80, valid = 1.
- **Flush mid-flight:**
  - 3 entries allocated; in one cycle assert flush_i together with issue_ack_i, commit_ack_i and a writeback.
  - Next cycle: count 0, commit_valid_o = 0, all rd_clobber_o = NONE; the next issue gets trans_id 0.
- **Wrap and async reset:**
  - Issue/commit 6 instructions → trans_id sequence 0,1,2,3,0,1.
  - Drop rst_ni mid-cycle → outputs go to reset values immediately, without waiting for a clock edge.
